wb_bus_decoder: RTL
===================

WB_BUS_DECODER -- requirements
Module: wb_bus_decoder

Interface
REQ-001 Parameter NumSlaves, default 4, number of downstream Wishbone slaves (1..4).
REQ-002 Parameter TimeoutCycles, default 255, cycles a slave may take before the block forces an error (1..255).
REQ-003 clk_i  input  1  single clock; all state updates on its rising edge.
REQ-004 reset_ni  input  1  reset; synchronous and active-low.
REQ-005 m_data_i / m_addr_i / m_sel_i  input  32 / 30 / 4  master write data, word address, byte selects.
REQ-006 m_cyc_i / m_stb_i / m_we_i  input  1 each  master cycle, strobe, write enable.
REQ-007 m_data_o  output  32  read data returned to master.
REQ-008 m_ack_o / m_err_o / m_stall_o  output  1 each  master ack, error, stall.
REQ-009 s_data_o / s_addr_o / s_sel_o / s_we_o  output  32 / 30 / 4 / 1  request fields, broadcast to all slaves.
REQ-010 s_cyc_o / s_stb_o  output  NumSlaves each  per-slave cycle and strobe.
REQ-011 s_data_i  input  32*NumSlaves  slave read data; slave k occupies bits [32k+31:32k].
REQ-012 s_ack_i / s_err_i / s_stall_i  input  NumSlaves each  per-slave ack, error, stall.

Function
REQ-013 Decode: region = m_addr_i[29:26]; region k < NumSlaves selects slave k; any other region is unmapped.
REQ-014 FSM states: IDLE, ISSUE, WAIT, FAULT; exactly one transaction outstanding at a time.
REQ-015 m_stall_o is 0 only in IDLE, 1 in all other states.
REQ-016 IDLE: on m_cyc_i & m_stb_i, latch addr/data/sel/we/target; go to ISSUE if mapped, otherwise FAULT.
REQ-017 ISSUE: s_cyc_o[k]=1, s_stb_o[k]=1 for the target k only; go to WAIT on the first cycle s_stall_i[k]=0.
REQ-018 WAIT: s_cyc_o[k]=1, s_stb_o[k]=0; hold until s_ack_i[k], s_err_i[k], timeout or abort.
REQ-019 s_ack_i[k] or s_err_i[k] seen in ISSUE or WAIT: end the transaction and return to IDLE the next cycle.
REQ-020 On s_ack_i[k]: register m_ack_o=1 for exactly one cycle and m_data_o = slave k data captured in the same cycle.
REQ-021 On s_err_i[k]: register m_err_o=1 for exactly one cycle.
REQ-022 s_ack_i[k] and s_err_i[k] together: error wins, m_ack_o stays 0.
REQ-023 Acks and errors from non-target slaves, or arriving in IDLE/FAULT, are ignored.
REQ-024 Timeout counter: cleared on entry to ISSUE, +1 per cycle in ISSUE/WAIT; reaching TimeoutCycles without ack/err gives m_err_o one-cycle pulse, return to IDLE.
REQ-025 FAULT: lasts one cycle, registers a one-cycle m_err_o pulse, returns to IDLE; no slave strobe issued.
REQ-026 Abort: m_cyc_i=0 in ISSUE or WAIT drops all s_cyc_o/s_stb_o that cycle, returns to IDLE, no ack/err.
REQ-027 m_data_o holds its last value except when updated on an ack.
REQ-028 Latency, zero-stall slave acking one cycle after strobe: request accepted cycle T, s_stb_o cycle T+1, m_ack_o cycle T+3.
REQ-029 A new request may be accepted in the same cycle m_ack_o/m_err_o is high.

Reset
REQ-030 While reset_ni=0 at a clock edge: state=IDLE, counter=0, m_ack_o=0, m_err_o=0, m_data_o=0, latched request fields=0.
REQ-031 Reset mid-transaction discards it: no ack/err; s_cyc_o/s_stb_o all 0 from the cycle after reset.

Verification
REQ-032 Write 0x0000_000A to region 0, slave 0 acks one cycle after strobe -> s_stb_o=0001 one cycle, s_data_o=0x0000_000A, m_ack_o at T+3.
REQ-033 Read region 2, slave 2 returns 0xDEAD_BEEF with ack after 2 stall cycles -> s_stb_o[2] held 3 cycles, m_data_o=0xDEAD_BEEF, single m_ack_o pulse.
REQ-034 Access region 9 -> m_err_o pulse at T+2, all s_stb_o stay 0, next request accepted normally.
REQ-035 TimeoutCycles=8, target slave never acks -> m_err_o pulse 8 cycles after ISSUE entry, s_cyc_o released, FSM back to IDLE.
REQ-036 s_ack_i and s_err_i together on target -> m_err_o=1, m_ack_o=0; non-target ack in WAIT -> ignored.
REQ-037 reset_ni=0 during WAIT, then m_cyc_i=0 in WAIT on a later request -> no ack/err either time, all outputs at reset values.

Source files
------------

// File: rtl/wb_bus_decoder_if.sv
// Wishbone master-side and per-slave signal bundle for wb_bus_decoder.
// The decoder takes the slave modport; the environment driving it takes master.
interface wb_bus_decoder_if #(
   parameter int NumSlaves = 4
);
   logic [31:0]             m_data_i;
   logic [29:0]             m_addr_i;
   logic [3:0]              m_sel_i;
   logic                    m_cyc_i;
   logic                    m_stb_i;
   logic                    m_we_i;
   logic [31:0]             m_data_o;
   logic                    m_ack_o;
   logic                    m_err_o;
   logic                    m_stall_o;

   logic [31:0]             s_data_o;
   logic [29:0]             s_addr_o;
   logic [3:0]              s_sel_o;
   logic                    s_we_o;
   logic [NumSlaves-1:0]    s_cyc_o;
   logic [NumSlaves-1:0]    s_stb_o;
   logic [32*NumSlaves-1:0] s_data_i;
   logic [NumSlaves-1:0]    s_ack_i;
   logic [NumSlaves-1:0]    s_err_i;
   logic [NumSlaves-1:0]    s_stall_i;

   modport master (
      output m_data_i, m_addr_i, m_sel_i, m_cyc_i, m_stb_i, m_we_i,
      input  m_data_o, m_ack_o, m_err_o, m_stall_o,
      input  s_data_o, s_addr_o, s_sel_o, s_we_o, s_cyc_o, s_stb_o,
      output s_data_i, s_ack_i, s_err_i, s_stall_i
   );

   modport slave (
      input  m_data_i, m_addr_i, m_sel_i, m_cyc_i, m_stb_i, m_we_i,
      output m_data_o, m_ack_o, m_err_o, m_stall_o,
      output s_data_o, s_addr_o, s_sel_o, s_we_o, s_cyc_o, s_stb_o,
      input  s_data_i, s_ack_i, s_err_i, s_stall_i
   );
endinterface

// File: rtl/wb_bus_decoder.sv
// Single-outstanding Wishbone 1:N address decoder with unmapped-region fault and timeout.
// Zero-stall slave acking one cycle after strobe: accept T, strobe T+1, m_ack_o T+3.
module wb_bus_decoder #(
   parameter int NumSlaves     = 4,
   parameter int TimeoutCycles = 255
) (
   input  logic              clk_i,
   input  logic              reset_ni,
   wb_bus_decoder_if.slave   bus
);
   localparam logic [1:0] IDLE  = 2'd0;
   localparam logic [1:0] ISSUE = 2'd1;
   localparam logic [1:0] WAIT  = 2'd2;
   localparam logic [1:0] FAULT = 2'd3;

   logic [1:0]           r_state;
   logic [7:0]           r_cnt;
   logic [1:0]           r_target;
   logic [29:0]          r_addr;
   logic [31:0]          r_data;
   logic [3:0]           r_sel;
   logic                 r_we;
   logic                 r_ack;
   logic                 r_err;
   logic [31:0]          r_rdata;

   logic [3:0]           w_region;
   logic                 w_mapped;
   logic [NumSlaves-1:0] w_tsel;
   logic                 w_busy;
   logic                 w_s_ack;
   logic                 w_s_err;
   logic                 w_s_stall;
   logic [31:0]          w_tgt_data;
   logic [7:0]           w_cnt_nxt;
   logic                 w_timeout;

   assign w_region = bus.m_addr_i[29:26];
   assign w_mapped = (w_region < 4'(NumSlaves));

   always_comb begin
      w_tsel     = '0;
      w_tgt_data = '0;
      for (int k = 0; k < NumSlaves; k++) begin
         w_tsel[k] = (r_target == 2'(k));
         if (r_target == 2'(k)) begin
            w_tgt_data = bus.s_data_i[32*k +: 32];
         end
      end
   end

   assign w_busy    = (r_state == ISSUE) || (r_state == WAIT);
   assign w_s_ack   = |(bus.s_ack_i & w_tsel);
   assign w_s_err   = |(bus.s_err_i & w_tsel);
   assign w_s_stall = |(bus.s_stall_i & w_tsel);
   assign w_cnt_nxt = r_cnt + 8'd1;
   assign w_timeout = (w_cnt_nxt == 8'(TimeoutCycles));

   // Dropping m_cyc_i releases the slave in the same cycle, not the next.
   assign bus.s_cyc_o   = (w_busy && bus.m_cyc_i) ? w_tsel : '0;
   assign bus.s_stb_o   = ((r_state == ISSUE) && bus.m_cyc_i) ? w_tsel : '0;
   assign bus.s_data_o  = r_data;
   assign bus.s_addr_o  = r_addr;
   assign bus.s_sel_o   = r_sel;
   assign bus.s_we_o    = r_we;
   assign bus.m_data_o  = r_rdata;
   assign bus.m_ack_o   = r_ack;
   assign bus.m_err_o   = r_err;
   assign bus.m_stall_o = (r_state != IDLE);

   always_ff @(posedge clk_i) begin
      if (!reset_ni) begin
         r_state  <= IDLE;
         r_cnt    <= '0;
         r_target <= '0;
         r_addr   <= '0;
         r_data   <= '0;
         r_sel    <= '0;
         r_we     <= 1'b0;
         r_ack    <= 1'b0;
         r_err    <= 1'b0;
         r_rdata  <= '0;
      end else begin
         r_ack <= 1'b0;
         r_err <= 1'b0;
         case (r_state)
            IDLE: begin
               if (bus.m_cyc_i && bus.m_stb_i) begin
                  r_addr   <= bus.m_addr_i;
                  r_data   <= bus.m_data_i;
                  r_sel    <= bus.m_sel_i;
                  r_we     <= bus.m_we_i;
                  r_target <= w_region[1:0];
                  r_cnt    <= '0;
                  r_state  <= w_mapped ? ISSUE : FAULT;
               end
            end
            ISSUE, WAIT: begin
               // Priority: abort, then error over ack, then timeout.
               if (!bus.m_cyc_i) begin
                  r_state <= IDLE;
               end else if (w_s_err) begin
                  r_err   <= 1'b1;
                  r_state <= IDLE;
               end else if (w_s_ack) begin
                  r_ack   <= 1'b1;
                  r_rdata <= w_tgt_data;
                  r_state <= IDLE;
               end else if (w_timeout) begin
                  r_err   <= 1'b1;
                  r_state <= IDLE;
               end else begin
                  r_cnt <= w_cnt_nxt;
                  if ((r_state == ISSUE) && !w_s_stall) begin
                     r_state <= WAIT;
                  end
               end
            end
            FAULT: begin
               r_err   <= 1'b1;
               r_state <= IDLE;
            end
         endcase
      end
   end
endmodule
